// File: rtl/temp_average_top.sv
// Sliding 8-sample temperature average shown on seven-segment digits and a character LCD.
// Latency: sample and sum update on the tick edge; HEX digits follow one edge later; LCD refreshes continuously.
// Backpressure: none; inputs are sampled at a fixed rate and the LCD bus is write-only and free-running.
module temp_average_top #(
    parameter int SAMPLE_DIV = 50_000_000,
    parameter int LCD_DIV    = 2_500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] temperatura,
    output logic [6:0] HEX_0,
    output logic [6:0] HEX_1,
    output logic [6:0] HEX_2,
    output logic       HEX_3,
    output logic [6:0] HEX_6,
    output logic [6:0] HEX_7,
    output logic       RW,
    output logic       EN,
    output logic       RS,
    output logic       ON,
    output logic [7:0] DATA
);
    localparam int SW       = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int WAIT_CYC = 40 * LCD_DIV;
    localparam int CW       = $clog2(WAIT_CYC);
    localparam logic [6:0] SEG_ZERO = 7'b1000000;

    typedef enum logic [3:0] {
        S_INIT_FUNC, S_INIT_DISP, S_INIT_CLR, S_CLR_WAIT, S_INIT_ENTRY,
        S_SET_ADDR, S_WR_SIGN, S_WR_H, S_WR_T, S_WR_U, S_WR_C
    } lcd_state_t;

    typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_HOLD} lcd_phase_t;

    // Seven-segment encoding, active-low gfedcba; blank for non-decimal input.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Byte sequence order: init chain runs once, then the refresh loop repeats.
    function automatic lcd_state_t next_byte_state(input lcd_state_t s);
        case (s)
            S_INIT_FUNC:  return S_INIT_DISP;
            S_INIT_DISP:  return S_INIT_CLR;
            S_INIT_CLR:   return S_CLR_WAIT;
            S_CLR_WAIT:   return S_INIT_ENTRY;
            S_INIT_ENTRY: return S_SET_ADDR;
            S_SET_ADDR:   return S_WR_SIGN;
            S_WR_SIGN:    return S_WR_H;
            S_WR_H:       return S_WR_T;
            S_WR_T:       return S_WR_U;
            S_WR_U:       return S_WR_C;
            S_WR_C:       return S_SET_ADDR;
            default:      return S_INIT_FUNC;
        endcase
    endfunction

    logic [SW-1:0] r_samp_cnt;
    logic          w_tick;
    logic [8:0]    r_buf [0:7];
    logic [2:0]    r_wr_ptr;
    logic [11:0]   r_sum;
    logic [6:0]    r_count;

    assign w_tick = (r_samp_cnt == SW'(SAMPLE_DIV - 1));

    // Sample timer, circular buffer and running sum (new sample in, oldest out).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_samp_cnt <= '0;
            r_wr_ptr   <= '0;
            r_sum      <= '0;
            r_count    <= '0;
            for (int i = 0; i < 8; i++) r_buf[i] <= '0;
        end else begin
            r_samp_cnt <= w_tick ? '0 : r_samp_cnt + SW'(1);
            if (w_tick) begin
                r_buf[r_wr_ptr] <= temperatura;
                r_sum    <= r_sum + {{3{temperatura[8]}}, temperatura}
                                  - {{3{r_buf[r_wr_ptr][8]}}, r_buf[r_wr_ptr]};
                r_wr_ptr <= r_wr_ptr + 3'd1;
                r_count  <= (r_count == 7'd99) ? 7'd0 : r_count + 7'd1;
            end
        end
    end

    logic signed [11:0] w_sum_s;
    logic signed [8:0]  w_avg;
    logic               w_neg;
    logic [8:0]         w_mag;
    logic [3:0]         w_hund, w_tens, w_unit, w_cnt_t, w_cnt_u;

    // Arithmetic shift floors toward minus infinity; |-256| needs the full 9 bits unsigned.
    assign w_sum_s = $signed(r_sum);
    assign w_avg   = 9'(w_sum_s >>> 3);
    assign w_neg   = w_avg[8];
    assign w_mag   = w_neg ? $unsigned(-w_avg) : $unsigned(w_avg);
    assign w_hund  = 4'(w_mag / 9'd100);
    assign w_tens  = 4'((w_mag / 9'd10) % 9'd10);
    assign w_unit  = 4'(w_mag % 9'd10);
    assign w_cnt_t = 4'(r_count / 7'd10);
    assign w_cnt_u = 4'(r_count % 7'd10);

    logic [6:0] r_hex0, r_hex1, r_hex2, r_hex6, r_hex7;
    logic       r_hex3;

    // Registered seven-segment outputs, refreshed every cycle from sum and count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hex0 <= SEG_ZERO;
            r_hex1 <= SEG_ZERO;
            r_hex2 <= SEG_ZERO;
            r_hex3 <= 1'b1;
            r_hex6 <= SEG_ZERO;
            r_hex7 <= SEG_ZERO;
        end else begin
            r_hex0 <= seg7(w_unit);
            r_hex1 <= seg7(w_tens);
            r_hex2 <= seg7(w_hund);
            r_hex3 <= ~w_neg;
            r_hex6 <= seg7(w_cnt_u);
            r_hex7 <= seg7(w_cnt_t);
        end
    end

    assign HEX_0 = r_hex0;
    assign HEX_1 = r_hex1;
    assign HEX_2 = r_hex2;
    assign HEX_3 = r_hex3;
    assign HEX_6 = r_hex6;
    assign HEX_7 = r_hex7;

    lcd_state_t  r_state, w_nxt_state;
    lcd_phase_t  r_phase, w_nxt_phase;
    logic [CW-1:0] r_cnt, w_nxt_cnt;
    logic [8:0]  w_nxt_byte;
    logic        w_nxt_en;
    logic        w_latch;
    logic        r_lat_neg;
    logic [3:0]  r_lat_h, r_lat_t, r_lat_u;
    logic        r_en, r_rs, r_on;
    logic [7:0]  r_data;

    // LCD sequencing: phase timer, byte advance, and the {RS,DATA}/EN the next cycle presents.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_phase = r_phase;
        w_nxt_cnt   = r_cnt + CW'(1);
        w_nxt_byte  = 9'h000;
        w_nxt_en    = 1'b0;
        if (r_state == S_CLR_WAIT) begin
            if (r_cnt == CW'(WAIT_CYC - 1)) begin
                w_nxt_state = S_INIT_ENTRY;
                w_nxt_phase = PH_SETUP;
                w_nxt_cnt   = '0;
            end
        end else if (r_cnt == CW'(LCD_DIV - 1)) begin
            w_nxt_cnt = '0;
            case (r_phase)
                PH_SETUP:  w_nxt_phase = PH_STROBE;
                PH_STROBE: w_nxt_phase = PH_HOLD;
                default: begin
                    w_nxt_phase = PH_SETUP;
                    w_nxt_state = next_byte_state(r_state);
                end
            endcase
        end
        case (w_nxt_state)
            S_INIT_FUNC:  w_nxt_byte = 9'h038;
            S_INIT_DISP:  w_nxt_byte = 9'h00C;
            S_INIT_CLR:   w_nxt_byte = 9'h001;
            S_CLR_WAIT:   w_nxt_byte = 9'h001;
            S_INIT_ENTRY: w_nxt_byte = 9'h006;
            S_SET_ADDR:   w_nxt_byte = 9'h080;
            S_WR_SIGN:    w_nxt_byte = {1'b1, (r_lat_neg ? 8'h2D : 8'h20)};
            S_WR_H:       w_nxt_byte = {1'b1, 4'h3, r_lat_h};
            S_WR_T:       w_nxt_byte = {1'b1, 4'h3, r_lat_t};
            S_WR_U:       w_nxt_byte = {1'b1, 4'h3, r_lat_u};
            S_WR_C:       w_nxt_byte = 9'h143;
            default:      w_nxt_byte = 9'h000;
        endcase
        w_nxt_en = (w_nxt_phase == PH_STROBE) && (w_nxt_state != S_CLR_WAIT);
    end

    // Snapshot the display value once per refresh so sign and digits always match.
    assign w_latch = (w_nxt_state == S_SET_ADDR) && (r_state != S_SET_ADDR);

    // LCD state register and registered bus outputs; reset aborts any transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_INIT_FUNC;
            r_phase   <= PH_SETUP;
            r_cnt     <= '0;
            r_en      <= 1'b0;
            r_rs      <= 1'b0;
            r_data    <= 8'h00;
            r_on      <= 1'b0;
            r_lat_neg <= 1'b0;
            r_lat_h   <= '0;
            r_lat_t   <= '0;
            r_lat_u   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_phase <= w_nxt_phase;
            r_cnt   <= w_nxt_cnt;
            r_en    <= w_nxt_en;
            r_rs    <= w_nxt_byte[8];
            r_data  <= w_nxt_byte[7:0];
            r_on    <= 1'b1;
            if (w_latch) begin
                r_lat_neg <= w_neg;
                r_lat_h   <= w_hund;
                r_lat_t   <= w_tens;
                r_lat_u   <= w_unit;
            end
        end
    end

    assign RW   = 1'b0;
    assign EN   = r_en;
    assign RS   = r_rs;
    assign ON   = r_on;
    assign DATA = r_data;

endmodule

// File: tb/tb_temp_average_top.sv
// Self-checking bench for temp_average_top with SAMPLE_DIV=4, LCD_DIV=2.
// Latency: checks HEX one edge after each sample tick; LCD bytes captured on EN rising.
// Backpressure: none; stimulus is free-running.
module tb_temp_average_top;
    localparam int SD = 4;
    localparam int LD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] temperatura = '0;
    logic [6:0] HEX_0, HEX_1, HEX_2, HEX_6, HEX_7;
    logic       HEX_3, RW, EN, RS, ON;
    logic [7:0] DATA;

    temp_average_top #(.SAMPLE_DIV(SD), .LCD_DIV(LD)) dut (
        .clk(clk), .rst(rst), .temperatura(temperatura),
        .HEX_0(HEX_0), .HEX_1(HEX_1), .HEX_2(HEX_2), .HEX_3(HEX_3),
        .HEX_6(HEX_6), .HEX_7(HEX_7),
        .RW(RW), .EN(EN), .RS(RS), .ON(ON), .DATA(DATA)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] seg_tab [10];
    logic [8:0] exp_lcd [10];

    // Reference model: last 8 samples, sample count, edges since last tick.
    int mq[$];
    int mcount = 0;
    int ph = 0;
    bit ticked = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int floor_div8(input int s);
        if (s >= 0) return s / 8;
        return -((-s + 7) / 8);
    endfunction

    function automatic logic [21:0] disp_of(input bit neg, input int h, input int t, input int u);
        return {~neg, seg_tab[h], seg_tab[t], seg_tab[u]};
    endfunction

    function automatic logic [21:0] model_disp();
        int s, a, m;
        s = 0;
        foreach (mq[i]) s += mq[i];
        a = floor_div8(s);
        m = (a < 0) ? -a : a;
        return disp_of(a < 0, m / 100, (m / 10) % 10, m % 10);
    endfunction

    function automatic logic [13:0] cnt_of(input int c);
        return {seg_tab[c / 10], seg_tab[c % 10]};
    endfunction

    task automatic step();
        @(posedge clk);
        ticked = 0;
        if (rst) begin
            mq.delete();
            repeat (8) mq.push_back(0);
            mcount = 0;
            ph = 0;
        end else if (ph == SD - 1) begin
            mq.push_back(int'($signed(temperatura)));
            void'(mq.pop_front());
            mcount = (mcount + 1) % 100;
            ph = 0;
            ticked = 1;
        end else begin
            ph++;
        end
        #1;
    endtask

    task automatic tick();
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!ticked && k <= SD);
        if (!ticked) chk("tick_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
    endtask

    // LCD monitor on the falling edge: byte on each EN rise, EN pulse widths, RW stuck low.
    logic [8:0] lcd_q[$];
    int  en_w[$];
    int  wcnt = 0;
    bit  prev_en = 0;
    bit  rw_bad = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (RW !== 1'b0) rw_bad = 1;
            if (rst) begin
                lcd_q.delete();
                en_w.delete();
                wcnt = 0;
                prev_en = 0;
            end else begin
                if (EN && !prev_en) lcd_q.push_back({RS, DATA});
                if (EN) wcnt++;
                else if (prev_en) begin
                    en_w.push_back(wcnt);
                    wcnt = 0;
                end
                prev_en = EN;
            end
        end
    end

    typedef struct {
        bit do_rst;
        int temp;
        int nt;
        int h, t, u;
        bit neg;
        int cnt;
    } vec_t;

    vec_t tab[7];

    initial begin
        int k;
        int bad_w;
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        exp_lcd = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h080,
                    9'h12D, 9'h130, 9'h131, 9'h136, 9'h143};
        tab[0] = '{1,   25, 1, 0, 0, 3, 0,  1};
        tab[1] = '{0,   25, 7, 0, 2, 5, 0,  8};
        tab[2] = '{1,  -16, 8, 0, 1, 6, 1,  8};
        tab[3] = '{1,   -1, 1, 0, 0, 1, 1,  1};
        tab[4] = '{1,  255, 8, 2, 5, 5, 0,  8};
        tab[5] = '{0, -256, 8, 2, 5, 6, 1, 16};
        tab[6] = '{0,    0, 8, 0, 0, 0, 0, 24};
        repeat (8) mq.push_back(0);

        // Reset state
        rst = 1'b1;
        repeat (5) step();
        chk("rst_disp", {HEX_3, HEX_2, HEX_1, HEX_0}, {1'b1, 7'b1000000, 7'b1000000, 7'b1000000});
        chk("rst_cnt", {HEX_7, HEX_6}, {7'b1000000, 7'b1000000});
        chk("rst_on", ON, 0);
        chk("rst_en", EN, 0);
        chk("rst_bus", {RS, DATA}, 9'h000);
        rst = 1'b0;
        step();
        chk("on_after_release", ON, 1);

        // Directed table
        for (int r = 0; r < 7; r++) begin
            if (tab[r].do_rst) do_reset();
            temperatura = 9'(tab[r].temp);
            for (int n = 0; n < tab[r].nt; n++) tick();
            step();
            chk($sformatf("row%0d_disp", r), {HEX_3, HEX_2, HEX_1, HEX_0},
                disp_of(tab[r].neg, tab[r].h, tab[r].t, tab[r].u));
            chk($sformatf("row%0d_cnt", r), {HEX_7, HEX_6}, cnt_of(tab[r].cnt));
        end

        // Random samples against the model, through the 99 -> 00 count wrap
        do_reset();
        for (int n = 0; n < 105; n++) begin
            temperatura = 9'($urandom_range(0, 511));
            tick();
            step();
            temperatura = 9'($urandom_range(0, 511));
            chk($sformatf("rand%0d_disp", n), {HEX_3, HEX_2, HEX_1, HEX_0}, model_disp());
            chk($sformatf("rand%0d_cnt", n), {HEX_7, HEX_6}, cnt_of(mcount));
        end
        chk("cnt_wrap", {HEX_7, HEX_6}, cnt_of(5));

        // LCD init and first refresh with a negative average
        do_reset();
        temperatura = 9'(-16);
        k = 0;
        while (lcd_q.size() < 10 && k < 400) begin
            step();
            k++;
        end
        chk("lcd_byte_count", (lcd_q.size() >= 10), 1);
        for (int i = 0; i < 10 && i < lcd_q.size(); i++)
            chk($sformatf("lcd_byte%0d", i), lcd_q[i], exp_lcd[i]);
        bad_w = 0;
        foreach (en_w[i]) if (en_w[i] != LD) bad_w++;
        chk("en_pulse_seen", (en_w.size() > 0), 1);
        chk("en_pulse_width", bad_w, 0);

        // Reset in the middle of a strobe
        k = 0;
        while (EN !== 1'b1 && k < 200) begin
            step();
            k++;
        end
        chk("en_wait", EN, 1);
        rst = 1'b1;
        step();
        chk("midrst_en", EN, 0);
        chk("midrst_on", ON, 0);
        rst = 1'b0;
        step();
        chk("midrst_disp", {HEX_3, HEX_2, HEX_1, HEX_0}, {1'b1, 7'b1000000, 7'b1000000, 7'b1000000});
        chk("midrst_cnt", {HEX_7, HEX_6}, {7'b1000000, 7'b1000000});
        k = 0;
        while (lcd_q.size() < 1 && k < 200) begin
            step();
            k++;
        end
        chk("midrst_first_seen", (lcd_q.size() >= 1), 1);
        if (lcd_q.size() >= 1) chk("midrst_first_byte", lcd_q[0], 9'h038);

        chk("rw_low", rw_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/temp_average_top.md
# temp_average_top

Top-level temperature-averaging display block. Samples a 9-bit signed temperature at a fixed rate and keeps a sliding 8-sample average. Shows the average in decimal on seven-segment displays and the sample count on two more digits. Also drives a write-only HD44780-style character LCD with the same average.

## Interface
- SAMPLE_DIV, default 50_000_000: clock cycles between samples (≥2).
- LCD_DIV, default 2_500: clock cycles per LCD bus phase (≥1).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- temperatura  in  9  temperature, two's complement signed, −256..255 °C.
- HEX_0  out  7  units digit of |average|; segments {g,f,e,d,c,b,a}, active-low.
- HEX_1  out  7  tens digit of |average|, active-low.
- HEX_2  out  7  hundreds digit of |average| (0–2), active-low.
- HEX_3  out  1  minus sign, active-low: 0 means average < 0.
- HEX_6  out  7  units digit of sample count, active-low.
- HEX_7  out  7  tens digit of sample count, active-low.
- RW  out  1  LCD read/write; tied 0 (write only).
- EN  out  1  LCD enable strobe.
- RS  out  1  LCD register select: 0 = command, 1 = data.
- ON  out  1  LCD power; 0 in reset, 1 otherwise.
- DATA  out  8  LCD data bus.

## Operation
- Sample tick: a counter runs 0..SAMPLE_DIV−1 and wraps. Tick = counter at SAMPLE_DIV−1.
- On a tick:
  - temperatura is written into an 8-entry circular buffer, overwriting the oldest entry.
  - 12-bit signed sum updates: sum += new − oldest.
  - Sample count increments modulo 100.
- Buffer entries reset to 0, so the average ramps up over the first 8 samples.
- Average = sum >>> 3 (arithmetic shift, rounds toward −∞). Result is 9-bit signed.
- Display value:
  - Magnitude = |average|, range 0..256.
  - Convert to BCD hundreds/tens/units.
  - All three digits are always shown, with leading zeros.
- Segment codes, active-low, gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- LCD FSM:
  - Init: INIT_FUNC (0x38), INIT_DISP (0x0C), INIT_CLR (0x01), CLR_WAIT (idle 40·LCD_DIV cycles), INIT_ENTRY (0x06).
  - Refresh loop: SET_ADDR (0x80, RS=0), then data bytes with RS=1: WR_SIGN, WR_H, WR_T, WR_U, WR_C, then back to SET_ADDR.
  - WR_SIGN sends '-' (0x2D) if negative, else ' ' (0x20). Digits are 0x30+d. WR_C sends 'C' (0x43).
  - Sign and digits are latched on entering SET_ADDR, so each refresh shows one consistent value.
- Byte transfer, 3 phases of LCD_DIV cycles each:
  - Setup: DATA/RS valid, EN=0.
  - Strobe: EN=1.
  - Hold: EN=0, DATA/RS held.
  - The next byte starts immediately after hold.

## Timing
- Reset, while rst=1 at a clock edge:
  - All counters cleared; buffer, sum and count set to 0; LCD FSM to INIT_FUNC phase setup.
  - HEX_0/1/2/6/7 = 1000000; HEX_3 = 1.
  - RW=0, EN=0, RS=0, ON=0, DATA=0x00.
- First tick occurs SAMPLE_DIV cycles after rst deasserts.
- Latency: sample captured and sum updated at tick edge E0. HEX outputs, registered, show the new average at edge E0+1. Count digits update at E0+1 too.
- Reset mid-operation aborts any LCD transfer: EN drops at the reset edge and init restarts.
- The temperatura value at the tick edge is used; changes between ticks are ignored.
- Count wraps 99 → 00.
- EN high pulse is exactly LCD_DIV cycles. One full refresh is 6 bytes × 3·LCD_DIV cycles.

## Test plan
All scenarios use SAMPLE_DIV=4 and LCD_DIV=2.
- Reset: hold rst=1 for 5 cycles → all HEX digits 1000000, HEX_3=1, ON=0, EN=0. Release → ON=1 next edge.
- Constant temperatura=25:
  - After 1 tick, average 3: HEX_0=0110000, HEX_1/HEX_2=1000000.
  - After 8 ticks, average 25: HEX_2=1000000, HEX_1=0100100, HEX_0=0010010.
  - HEX_7/HEX_6 show "08".
- Negative and rounding:
  - temperatura=−16 for 8 ticks → HEX_3=0, display "016", LCD bytes 0x2D 0x30 0x31 0x36 0x43.
  - A single −1 sample from reset → average −1, display "001" with HEX_3=0.
- Extremes:
  - 255 for 8 ticks → "255", HEX_3=1.
  - −256 for 8 ticks → "256", HEX_3=0.
  - Then 0 for 8 ticks → "000".
- LCD: after reset, bytes in order with correct RS are 0x38, 0x0C, 0x01, 0x06, 0x80, then 5 data bytes. EN pulses are 2 cycles wide. RW is constantly 0.
- Reset mid-transfer: assert rst while EN=1 → EN=0 at that edge; sum and count cleared; init sequence restarts from 0x38.
